branch_predictor: RTL

- Dynamic branch predictor for the five-stage pipeline.
- Combinational lookup in Fetch produces the prediction and predicted target.
- The prediction travels down the pipeline and is compared against the resolved outcome in Execute; the hazard unit uses that comparison to decide the flush.
- Synchronous update from Execute trains a direct-mapped table that combines a branch target buffer with 2-bit saturating counters.
- Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 95 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: a branch target buffer combined with 2-bit saturating
// counters. Fetch reads it combinationally, Execute trains it synchronously, and it counts branches and mispredicts.
module branch_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc_F,
    output logic                prediction_F,
    output logic [PC_WIDTH-1:0] predicted_target_F,
    input  logic                update_en_E,
    input  logic [PC_WIDTH-1:0] pc_E,
    input  logic                actual_outcome_E,
    input  logic [PC_WIDTH-1:0] target_E,
    input  logic                prediction_E,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] idx_F;
    logic [TAG_BITS-1:0]   tag_F;
    logic [INDEX_BITS-1:0] idx_E;
    logic [TAG_BITS-1:0]   tag_E;
    logic                  hit_F;
    logic                  hit_E;

    assign idx_F = pc_F[INDEX_BITS+1:2];
    assign tag_F = pc_F[TAG_HI:TAG_LO];
    assign idx_E = pc_E[INDEX_BITS+1:2];
    assign tag_E = pc_E[TAG_HI:TAG_LO];

    // Byte offset and PC bits above the tag do not take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_F[PC_WIDTH-1:TAG_HI+1], pc_F[1:0],
                              pc_E[PC_WIDTH-1:TAG_HI+1], pc_E[1:0]};

    // Lookup reads the registered table only, so a same-cycle update is seen one cycle later.
    always_comb begin
        hit_F              = valid_q[idx_F] && (tag_q[idx_F] == tag_F);
        prediction_F       = 1'b0;
        predicted_target_F = '0;
        if (hit_F && ctr_q[idx_F][1]) begin
            prediction_F       = 1'b1;
            predicted_target_F = target_q[idx_F];
        end
    end

    assign hit_E = valid_q[idx_E] && (tag_q[idx_E] == tag_E);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (update_en_E) begin
            branch_count <= branch_count + 32'd1;
            if (prediction_E != actual_outcome_E) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
            if (hit_E) begin
                if (actual_outcome_E) begin
                    target_q[idx_E] <= target_E;
                    if (ctr_q[idx_E] != 2'b11) begin
                        ctr_q[idx_E] <= ctr_q[idx_E] + 2'd1;
                    end
                end else if (ctr_q[idx_E] != 2'b00) begin
                    ctr_q[idx_E] <= ctr_q[idx_E] - 2'd1;
                end
            end else if (actual_outcome_E) begin
                // Allocation replaces whatever branch currently aliases this index.
                valid_q[idx_E]  <= 1'b1;
                tag_q[idx_E]    <= tag_E;
                target_q[idx_E] <= target_E;
                ctr_q[idx_E]    <= 2'b10;
            end
        end
    end

endmodule
